// File: rtl/div_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//  - state_e       : control FSM encoding (IDLE / RUN / DONE)
//  - DBZ_QUOTIENT  : all-ones quotient returned on divide-by-zero. The top
//                    takes its low N bits, so N may not exceed 64.
package div_restoring_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          DBZ_QUOTIENT_W = 64;
    localparam logic [63:0] DBZ_QUOTIENT   = '1;

endpackage

// File: rtl/div_restoring_seq_adder_la4.sv
// adder_la4: N-bit adder built from 4-bit carry-lookahead groups. Carries
// are fully looked ahead inside each group and rippled between groups.
// Ports:
//  a, b  in  N  addends
//  cin   in  1  carry into bit 0
//  sum   out N  a + b + cin (low N bits)
//  cout  out 1  carry out of bit N-1
// N must be a multiple of 4.
module adder_la4 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NG = N / 4;

    // carry[gi] is the carry into group gi; carry[NG] leaves the adder.
    logic [NG:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[NG];

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            logic [3:0] p;
            logic [3:0] g;
            logic [3:0] c;

            assign p = a[4*gi +: 4] ^ b[4*gi +: 4];
            assign g = a[4*gi +: 4] & b[4*gi +: 4];

            // Lookahead carries within the group, all from the group carry-in.
            assign c[0] = carry[gi];
            assign c[1] = g[0] | (p[0] & carry[gi]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry[gi]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & carry[gi]);
            assign carry[gi+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                               | (p[3] & p[2] & p[1] & g[0])
                               | (p[3] & p[2] & p[1] & p[0] & carry[gi]);

            assign sum[4*gi +: 4] = p ^ c;
        end
    endgenerate

endmodule

// File: rtl/div_restoring_seq.sv
// div_restoring_seq: iterative unsigned restoring divider, one quotient bit
// per clock, valid/ready on both sides.
// Ports:
//  clk          in   1  clock, all state on posedge
//  rst          in   1  synchronous active-high reset
//  in_valid     in   1  operands valid
//  in_ready     out  1  high only in IDLE
//  dividend     in   N  unsigned dividend
//  divisor      in   N  unsigned divisor
//  out_valid    out  1  high only in DONE
//  out_ready    in   1  consumer takes result
//  quotient     out  N  unsigned quotient
//  remainder    out  N  unsigned remainder
//  div_by_zero  out  1  divisor was zero for this result
// Outputs are flops or decodes of the state flop only; there is no
// combinational path from any input to any output.
module div_restoring_seq
    import div_restoring_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;      // dividend shifting out / quotient shifting in
    logic [N-1:0]  r_q, r_d;      // partial remainder
    logic [N-1:0]  d_q, d_d;      // latched divisor
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    // Trial subtraction S - D through the lookahead adder.
    logic [N-1:0] shift_rem;
    logic         top_bit;
    logic [N-1:0] diff;
    logic         no_borrow;
    logic         ok;

    assign shift_rem = {r_q[N-2:0], q_q[N-1]};
    assign top_bit   = r_q[N-1];

    adder_la4 #(.N(N)) u_sub (
        .a    (shift_rem),
        .b    (~d_q),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // The shifted remainder is really N+1 bits wide; a set top bit means it
    // already exceeds any N-bit divisor, so the subtraction always fits.
    assign ok = top_bit | no_borrow;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    q_d   = dividend;
                    r_d   = '0;
                    d_d   = divisor;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        quot_d  = DBZ_QUOTIENT[N-1:0];
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_d   = ok ? diff : shift_rem;
                q_d   = {q_q[N-2:0], ok};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq (N=32): directed corner cases,
// backpressure, mid-run reset, then randomized back-to-back operations
// checked against plain a/b, a%b arithmetic.
module tb_div_restoring_seq;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int tests_run;
    int tests_failed;

    div_restoring_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic, divide-by-zero returns all ones / dividend.
    task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic dbz);
        if (b == 0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
        end
    endtask

    // Called and returns at a negedge. Issues one operation, measures the
    // latency in clock edges (accept edge included), checks the result,
    // holds backpressure for bp cycles, then completes the handshake.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int bp);
        logic [N-1:0] eq, er;
        logic         edbz;
        int           lat;
        int           exp_lat;

        ref_div(a, b, eq, er, edbz);
        exp_lat = (b == 0) ? 1 : N + 1;

        check_eq("in_ready_before", 64'(in_ready), 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("quotient", 64'(quotient), 64'(eq));
        check_eq("remainder", 64'(remainder), 64'(er));
        check_eq("div_by_zero", 64'(div_by_zero), 64'(edbz));
        $display("[TB] op 0x%08h / 0x%08h -> q=0x%08h r=0x%08h dbz=%0d lat=%0d",
                 a, b, quotient, remainder, div_by_zero, lat);

        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            in_valid  = $urandom_range(0, 1);
            dividend  = $urandom;
            divisor   = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_quotient", 64'(quotient), 64'(eq));
            check_eq("bp_remainder", 64'(remainder), 64'(er));
            check_eq("bp_dbz", 64'(div_by_zero), 64'(edbz));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_out_valid", 64'(out_valid), 64'd0);
        check_eq("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] ra, rb;

        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_quotient", 64'(quotient), 64'd0);
        check_eq("rst_remainder", 64'(remainder), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);

        // Directed corner cases; 100/7 also holds 10 cycles of backpressure.
        run_op(32'd100, 32'd7, 10);
        run_op(32'd5, 32'd9, 0);
        run_op(32'd0, 32'd3, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 0);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_op(32'd1234, 32'd0, 2);

        // Hard-coded expectations for the headline cases, independent of ref_div.
        run_op(32'd100, 32'd7, 0);
        check_eq("const_100_7_q", 64'(quotient), 64'd14);
        check_eq("const_100_7_r", 64'(remainder), 64'd2);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 0);
        check_eq("const_t1_q", 64'(quotient), 64'd1);
        check_eq("const_t1_r", 64'(remainder), 64'h7FFF_FFFE);

        // Reset in the middle of RUN discards the result.
        dividend = 32'd77777;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_quotient", 64'(quotient), 64'd0);
        check_eq("midrst_remainder", 64'(remainder), 64'd0);
        check_eq("midrst_dbz", 64'(div_by_zero), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("midrst_stays_idle", 64'(out_valid), 64'd0);
        run_op(32'd1000, 32'd10, 0);
        check_eq("const_1000_10_q", 64'(quotient), 64'd100);

        // Random back-to-back operations.
        for (int n = 0; n < 500; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = ra;
                3:       rb = $urandom | 32'h8000_0000;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(ra, rb, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
